// File: rtl/producer_arbiter.sv
// Round-robin arbiter: merges NUM_REQ valid/ready producers onto one registered consumer channel.
// Optional burst hold (up to MAX_BURST beats per grant) is built when PRODUCER_ARBITER_BURST_HOLD_EN is defined.
module producer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic [$clog2(NUM_REQ)-1:0] data_src,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
    $error("producer_arbiter: parameter out of range");
  end

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Returns {found, index} of the first valid requester at or after base, wrapping.
  function automatic logic [IW:0] f_pick(input logic [NUM_REQ-1:0] vld,
                                         input logic [IW-1:0]      base);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (vld[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [IW-1:0]     r_src;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nx;
  logic              w_load;
  logic              w_xfer;
  logic              w_gnt_vld;
  logic [IW-1:0]     w_gnt;
  logic [IW:0]       w_pick;
  logic [DATA_W-1:0] w_beat;

  assign w_load = !r_valid || data_ready;
  assign w_xfer = w_load && w_gnt_vld;
  assign w_beat = req_data[int'(w_gnt)*DATA_W +: DATA_W];

`ifdef PRODUCER_ARBITER_BURST_HOLD_EN
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nx;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nx;
  logic          w_owner_hit;
  logic [IW-1:0] w_base;

  // A dropped owner re-arbitrates from owner+1 in the same cycle, so no bubble.
  assign w_owner_hit = (r_state == S_HOLD) && req_valid[r_owner];
  assign w_base      = (r_state == S_HOLD) ? f_inc(r_owner) : r_ptr;
  assign w_pick      = f_pick(req_valid, w_base);
  assign w_gnt_vld   = w_owner_hit || w_pick[IW];
  assign w_gnt       = w_owner_hit ? r_owner : w_pick[IW-1:0];
  assign busy        = (r_state == S_HOLD);

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    if (w_load) begin
      if (w_owner_hit) begin
        if (r_cnt + 4'd1 == 4'(MAX_BURST)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_ptr_nx   = f_inc(r_owner);
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end else begin
        if (r_state == S_HOLD) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_ptr_nx   = f_inc(r_owner);
        end
        if (w_xfer) begin
          if (MAX_BURST == 1) begin
            w_ptr_nx = f_inc(w_gnt);
          end else begin
            w_state_nx = S_HOLD;
            w_owner_nx = w_gnt;
            w_cnt_nx   = 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
`else
  assign w_pick    = f_pick(req_valid, r_ptr);
  assign w_gnt_vld = w_pick[IW];
  assign w_gnt     = w_pick[IW-1:0];
  assign w_ptr_nx  = w_xfer ? f_inc(w_gnt) : r_ptr;
  assign busy      = 1'b0;
`endif

  always_comb begin
    req_ready = '0;
    if (w_xfer && rst_n) req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      r_ptr <= w_ptr_nx;
      if (w_load) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_data <= w_beat;
          r_src  <= w_gnt;
        end
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign data_src   = r_src;
endmodule

// File: tb/tb_producer_arbiter.sv
// Bench for producer_arbiter: per-producer beat queues, spec-level grant model, and a
// scoreboard monitor that checks every consumed beat's data and source.
module tb_producer_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;
`ifdef PRODUCER_ARBITER_BURST_HOLD_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic            data_ready = 1'b0;
  logic [IW-1:0]   data_src;
  logic            busy;

  always #5 clk = ~clk;

  producer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .data_src(data_src), .busy(busy)
  );

  typedef logic [DW-1:0] bq_t[$];
  typedef struct packed {logic [IW-1:0] src; logic [DW-1:0] data;} beat_t;

  int           total = 0;
  int           bad = 0;
  bq_t          pq[N];
  beat_t        exp_q[$];
  int           src_log[$];
  logic [N-1:0] en = '0;
  logic         cons_rdy = 1'b1;
  logic [N-1:0] last_rdy;
  int           m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit           m_hold = 0, m_dv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  // Round robin from the pointer; a held burst keeps its owner while it stays valid.
  function automatic int model_grant(input logic [N-1:0] v);
    int base;
    if (BURST && m_hold && v[m_owner]) return m_owner;
    base = (BURST && m_hold) ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++)
      if (v[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] v, exp_rdy;
    int g;
    bit load, xfer;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      v[i] = en[i] && (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    req_valid  = v;
    data_ready = cons_rdy;
    #1;
    load = !m_dv || cons_rdy;
    g = model_grant(v);
    xfer = load && (g >= 0);
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    last_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_hold));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    if (xfer) begin
      exp_q.push_back('{src: IW'(g), data: pq[g][0]});
      void'(pq[g].pop_front());
    end
    if (load) begin
      if (BURST) begin
        if (m_hold && v[m_owner]) begin
          m_cnt++;
          if (m_cnt == MB) begin m_hold = 0; m_ptr = (m_owner + 1) % N; end
        end else begin
          if (m_hold) begin m_hold = 0; m_ptr = (m_owner + 1) % N; end
          if (xfer) begin
            if (MB == 1) m_ptr = (g + 1) % N;
            else begin m_hold = 1; m_owner = g; m_cnt = 1; end
          end
        end
      end else if (xfer) begin
        m_ptr = (g + 1) % N;
      end
      m_dv = xfer;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    data_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_src", 32'(data_src), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_hold = 0; m_dv = 0;
    exp_q.delete();
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    en = '1;
    cons_rdy = 1'b1;
    for (int c = 0; c < 300 && (pending() > 0 || m_dv); c++) cycle();
    cycle();
    en = '0;
  endtask

  // Monitor: checks every consumed beat against the scoreboard and stall stability.
  initial begin
    bit prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_src;
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (prev_stall) begin
          chk("stall_valid", 32'(data_valid), 32'h1);
          chk("stall_data", 32'(data_out), 32'(prev_data));
          chk("stall_src", 32'(data_src), 32'(prev_src));
        end
        if (data_valid && data_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual=%0h/%0h required=none", data_src, data_out);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(data_out), 32'(e.data));
            chk("beat_src", 32'(data_src), 32'(e.src));
            src_log.push_back(int'(data_src));
          end
        end
        prev_stall = data_valid && !data_ready;
        prev_data  = data_out;
        prev_src   = data_src;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    do_reset();

    // Single producer 2 streams 0x10..0x17.
    for (int b = 0; b < 8; b++) pq[2].push_back(8'(8'h10 + b));
    en = 4'b0100;
    cons_rdy = 1'b1;
    repeat (10) cycle();
    drain();

    // All four valid; reset mid-stream, then check grant order from producer 0.
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 12; b++) pq[i].push_back(8'((i << 4) + b));
    en = 4'b1111;
    repeat (3) cycle();
    do_reset();
    src_log.delete();
    repeat (25) cycle();
    chk("order_len", 32'(src_log.size() >= 20), 32'h1);
    if (src_log.size() >= 20)
      for (int i = 0; i < 20; i++)
        chk("grant_order", 32'(src_log[i]), BURST ? 32'((i / MB) % N) : 32'(i % N));
    drain();

    // Backpressure with 0xA5 held from producer 1.
    pq[1].push_back(8'hA5); pq[1].push_back(8'hA6); pq[1].push_back(8'hA7);
    en = 4'b0010;
    cons_rdy = 1'b0;
    cycle();
    repeat (5) cycle();
    chk("bp_data", 32'(data_out), 32'hA5);
    chk("bp_ready", 32'(last_rdy), 32'h0);
    cons_rdy = 1'b1;
    repeat (6) cycle();
    drain();

    // Owner drops after 2 beats; next producer granted in the same cycle.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      pq[0].push_back(8'(8'h40 + b));
      pq[1].push_back(8'(8'h50 + b));
    end
    en = 4'b0011;
    cycle();
    cycle();
    en = 4'b0010;
    cycle();
    chk("drop_regrant", 32'(last_rdy), 32'h2);
    cycle();
    chk("no_bubble", 32'(data_valid), 32'h1);
    drain();

    // Wrap-around with ptr at 3.
    do_reset();
    pq[2].push_back(8'h33);
    en = 4'b0100;
    cycle();
    en = 4'b0000;
    cycle();
    pq[3].push_back(8'h30); pq[3].push_back(8'h31);
    pq[0].push_back(8'h00); pq[0].push_back(8'h01);
    en = 4'b1001;
    cycle();
    chk("wrap_first", 32'(last_rdy), 32'h8);
    repeat (6) cycle();
    drain();

    // Randomized traffic with random backpressure and one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 3 && $urandom_range(1) == 1) pq[i].push_back(8'($urandom));
      en = N'($urandom);
      cons_rdy = ($urandom_range(3) != 0);
      cycle();
    end
    drain();
    @(negedge clk);
    #3;
    chk("drain_empty", 32'(exp_q.size() + pending()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
